// File: rtl/lut_table_writer.sv
// Byte-stream driven lookup table: header bytes select write/clear operations,
// payload bytes fill the table from a wrapping pointer; one registered read port.
module lut_table_writer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   wr_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                xfer;
    logic                hdr;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_val;

    assign xfer   = in_valid & in_ready;
    assign hdr    = xfer & in_sof;
    assign wr_en  = (state == CLEAR) | ((state == WRITE) & xfer & ~in_sof);
    assign wr_val = (state == CLEAR) ? '0 : DATA_W'(in_data);

    // Control FSM; busy/in_ready are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            wr_count <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    if (hdr) begin
                        wr_count <= '0;
                        case (in_data[7:6])
                            2'b00: begin
                                state <= WRITE;
                                ptr   <= ADDR_W'(in_data[5:0]);
                            end
                            2'b01: begin
                                state    <= CLEAR;
                                ptr      <= '0;
                                busy     <= 1'b1;
                                in_ready <= 1'b0;
                            end
                            default: begin
                                state <= IDLE;
                                ptr   <= ADDR_W'(in_data[5:0]);
                                err   <= 1'b1;
                            end
                        endcase
                    end else if (xfer) begin
                        if (state == WRITE) begin
                            ptr <= ptr + 1'b1;
                            if (wr_count != CNT_MAX)
                                wr_count <= wr_count + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Read samples pre-write contents, so a same-address collision returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en)
                mem[ptr] <= wr_val;
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: doc/lut_table_writer.md
LUT_TABLE_WRITER -- requirements
Module: lut_table_writer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 6, table address width (64 entries).
REQ-002 SHALL provide parameter DATA_W, default 8, entry width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 in_valid  input  1  stream byte present.
REQ-006 in_sof  input  1  qualifies the current byte as a frame header; ignored unless in_valid=1.
REQ-007 in_data  input  8  header or payload byte.
REQ-008 in_ready  output  1  block accepts byte this cycle; transfer = in_valid & in_ready.
REQ-009 rd_addr  input  ADDR_W  table read address.
REQ-010 rd_data  output  DATA_W  registered table contents at rd_addr.
REQ-011 busy  output  1  high while a clear operation runs.
REQ-012 err  output  1  sticky protocol-error flag.
REQ-013 wr_count  output  ADDR_W+1  payload bytes written since last header; saturates at 64.

Function
REQ-014 States SHALL be IDLE, WRITE, CLEAR.
REQ-015 Header byte: in_data[7:6]=opcode, in_data[5:0]=start address.
REQ-016 Header accepted in any state except CLEAR; it aborts any current burst, loads pointer = in_data[5:0], clears wr_count to 0.
REQ-017 Opcode 00 -> WRITE; each following payload transfer writes mem[ptr] <= in_data, ptr <= ptr+1 mod 64, wr_count += 1 (saturating).
REQ-018 Pointer wrap 63 -> 0 SHALL be silent; burst continues, overwriting from entry 0.
REQ-019 Opcode 01 -> CLEAR; writes 0x00 to one entry per cycle, entries 0..63 in order, 64 cycles, then IDLE; start-address field ignored.
REQ-020 Opcodes 10 and 11 SHALL set err, leave table untouched, go IDLE.
REQ-021 Payload byte (in_sof=0) transferred in IDLE SHALL set err and be discarded.
REQ-022 in_ready SHALL be 1 in IDLE and WRITE, 0 in CLEAR; busy = (state==CLEAR).
REQ-023 Table write visible to read port one cycle after the write edge; rd_data registered, latency 1 cycle from rd_addr.
REQ-024 Read and write to same address in same cycle SHALL return the old contents on rd_data next cycle.
REQ-025 err is sticky; cleared only by rst.
REQ-026 Transfers with in_valid=0 SHALL not change state, pointer, table or wr_count.

Reset
REQ-027 rst SHALL immediately force state IDLE, pointer 0, wr_count 0, err 0, busy 0, rd_data 0x00, in_ready 1 after release.
REQ-028 rst SHALL clear all 64 table entries to 0x00.
REQ-029 rst asserted mid-WRITE or mid-CLEAR SHALL abort the operation with no further writes after deassertion.

Verification
REQ-030 Header 0x00, payload 0x11,0x22,0x33 -> entries 0..2 = 11,22,33; wr_count=3; err=0.
REQ-031 Header 0x3E, payload 0xAA,0xBB,0xCC -> entries 62=AA, 63=BB, 0=CC; wr_count=3.
REQ-032 Table loaded, header 0x40 -> busy=1, in_ready=0 for exactly 64 cycles; afterwards all entries read 0x00.
REQ-033 Payload 0x55 with in_sof=0 in IDLE -> err=1, table unchanged; header 0x80 -> err stays 1, table unchanged.
REQ-034 rd_addr=5 while writing 0x77 to entry 5 (old 0x12) -> rd_data next cycle 0x12, following cycle 0x77.
REQ-035 rst pulsed during CLEAR at entry 20 -> all entries 0x00, state IDLE, busy=0, err=0.
